// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side streams, the single UART-side stream and grant status for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           s_valid;
  logic [NUM_REQ*DATA_BITS-1:0] s_data;
  logic [NUM_REQ-1:0]           s_last;
  logic [NUM_REQ-1:0]           s_ready;
  logic                         m_valid;
  logic [DATA_BITS-1:0]         m_data;
  logic                         m_ready;
  logic                         grant_valid;
  logic [GRANT_W-1:0]           grant_id;
  logic [7:0]                   burst_cnt;
  logic                         dbg_state;
  logic [GRANT_W-1:0]           dbg_rr_ptr;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, grant_valid, grant_id, burst_cnt, dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, grant_valid, grant_id, burst_cnt, dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte streams; a grant lasts
// until the owner's 'last' byte or MAX_BURST bytes, then the pointer moves past the owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int MAX_BURST = 16
) (
  input  logic             aclk,
  input  logic             areset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a byte moves in any cycle where valid and ready are both high at the clock edge;
  // the arbiter is a pure combinational path, so m_valid/m_data/s_ready follow the owner directly.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e               state_q;
  logic [GRANT_W-1:0]   rr_ptr_q;
  logic [GRANT_W-1:0]   grant_id_q;
  logic                 grant_valid_q;
  logic [7:0]           burst_cnt_q;

  logic [GRANT_W-1:0]   pick;
  logic                 pick_found;
  logic                 owner_valid;
  logic                 owner_last;
  logic [DATA_BITS-1:0] owner_data;
  logic                 xfer;
  logic                 burst_hit;
  logic                 release_now;
  logic [GRANT_W-1:0]   rr_next;

  always_comb begin : rr_pick
    logic [GRANT_W-1:0] idx;
    idx        = '0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GRANT_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && bus.s_valid[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin : owner_mux
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GRANT_W'(i)) begin
        owner_valid = bus.s_valid[i];
        owner_last  = bus.s_last[i];
        owner_data  = bus.s_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin : pass_through
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.s_ready = '0;
    if (state_q == GRANT) begin
      bus.m_valid = owner_valid;
      if (owner_valid) bus.m_data = owner_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == GRANT_W'(i)) bus.s_ready[i] = bus.m_ready;
      end
    end
  end

  assign xfer        = (state_q == GRANT) && owner_valid && bus.m_ready;
  assign burst_hit   = ({1'b0, burst_cnt_q} + 9'd1) == 9'(MAX_BURST);
  assign release_now = xfer && (owner_last || burst_hit);
  assign rr_next     = (grant_id_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      burst_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q    <= pick;
            grant_valid_q <= 1'b1;
            burst_cnt_q   <= '0;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            // burst_cnt keeps the final count of the finished grant until the next one starts
            burst_cnt_q <= burst_cnt_q + 8'd1;
            if (release_now) begin
              grant_valid_q <= 1'b0;
              rr_ptr_q      <= rr_next;
              state_q       <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.burst_cnt   = burst_cnt_q;
  assign bus.dbg_state   = (state_q == GRANT);
  assign bus.dbg_rr_ptr  = rr_ptr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-requester message queues, a round-robin reference
// model tracking owner/pointer/count, and an end-to-end byte scoreboard per requester.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_BITS = 8;
  localparam int MAX_BURST = 16;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .MAX_BURST(MAX_BURST)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // source side: {last, data}; scoreboard side: bytes still owed to the UART per requester
  logic [8:0]           src_q[NUM_REQ][$];
  logic [DATA_BITS-1:0] exp_q[NUM_REQ][$];
  bit                   hold[NUM_REQ];
  bit                   gap_en;
  bit                   slow_ready;

  // reference model: owner (-1 = nobody), pointer, bytes in grant, last granted index
  int mo, mp, mc, mg;

  int order_q[$];
  int len_q[$];
  int obs_cnt, max_cnt;
  bit prev_gv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    mo = -1; mp = 0; mc = 0; mg = 0;
    prev_gv = 1'b0; obs_cnt = 0;
  endtask

  task automatic clear_obs();
    order_q.delete(); len_q.delete();
    obs_cnt = 0; max_cnt = 0;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    src_q[r].push_back({last, d});
    exp_q[r].push_back(d);
  endtask

  task automatic send_msg(input int r, input int len, input bit with_last);
    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), with_last && (b == len - 1));
  endtask

  task automatic check_half();
    logic                 exp_mv;
    logic [DATA_BITS-1:0] exp_md;
    logic [NUM_REQ-1:0]   exp_sr;
    exp_mv = (mo >= 0) ? bus.s_valid[mo] : 1'b0;
    exp_md = exp_mv ? bus.s_data[mo*DATA_BITS +: DATA_BITS] : '0;
    exp_sr = '0;
    if (mo >= 0 && bus.m_ready) exp_sr[mo] = 1'b1;
    check("grant_valid", bus.grant_valid, (mo >= 0));
    check("grant_id", bus.grant_id, mg);
    check("burst_cnt", bus.burst_cnt, mc);
    check("rr_ptr", bus.dbg_rr_ptr, mp);
    check("fsm_state", bus.dbg_state, (mo >= 0));
    check("m_valid", bus.m_valid, exp_mv);
    check("m_data", bus.m_data, exp_md);
    check("s_ready", bus.s_ready, exp_sr);
    if (!prev_gv && bus.grant_valid) order_q.push_back(int'(bus.grant_id));
    if (prev_gv && !bus.grant_valid) begin
      len_q.push_back(obs_cnt);
      obs_cnt = 0;
    end
    prev_gv = bus.grant_valid;
    if (int'(bus.burst_cnt) > max_cnt) max_cnt = int'(bus.burst_cnt);
  endtask

  // everything decided here describes the coming rising edge; inputs stay put until after it
  task automatic advance_half();
    int idx;
    if (bus.m_valid && bus.m_ready) begin
      obs_cnt++;
      if (mo < 0 || exp_q[(mo < 0) ? 0 : mo].size() == 0) check("sb_unexpected", bus.m_valid, 0);
      else check("sb_byte", bus.m_data, exp_q[mo].pop_front());
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.s_valid[i] && bus.s_ready[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        hold[i] = 1'b0;
      end
    end
    if (mo < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (mp + k) % NUM_REQ;
        if (mo < 0 && bus.s_valid[idx]) begin
          mo = idx; mg = idx; mc = 0;
        end
      end
    end else if (bus.s_valid[mo] && bus.m_ready) begin
      mc++;
      if (bus.s_last[mo] || mc == MAX_BURST) begin
        mp = (mo + 1) % NUM_REQ;
        mo = -1;
      end
    end
  endtask

  task automatic drive();
    logic [8:0] head;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() == 0) hold[i] = 1'b0;
      else if (!hold[i]) hold[i] = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      head = (src_q[i].size() > 0) ? src_q[i][0] : 9'h000;
      bus.s_valid[i] = hold[i];
      bus.s_data[i*DATA_BITS +: DATA_BITS] = hold[i] ? head[7:0] : DATA_BITS'($urandom);
      bus.s_last[i] = hold[i] ? head[8] : 1'b0;
    end
    bus.m_ready = slow_ready ? ($urandom_range(0, 39) == 0) : 1'b1;
  endtask

  task automatic tick();
    @(negedge aclk);
    check_half();
    advance_half();
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (pending() && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_timeout", pending(), 0);
    repeat (3) tick();
  endtask

  // asserted between edges: outputs must collapse before any clock edge arrives
  task automatic pulse_reset();
    areset = 1'b1;
    #1;
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_burst_cnt", bus.burst_cnt, 0);
    check("rst_rr_ptr", bus.dbg_rr_ptr, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_s_ready", bus.s_ready, 0);
    model_reset();
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    int n;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b0;
    gap_en = 1'b0;
    slow_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;
    model_reset();
    clear_obs();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    pulse_reset();
    drive();

    // idle after reset
    repeat (20) tick();

    // single requester, three-byte message
    clear_obs();
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b1);
    drain(100);
    check("t2_rr_ptr", bus.dbg_rr_ptr, 1);
    check("t2_grants", order_q.size(), 1);
    check("t2_len_cnt", len_q.size(), 1);
    foreach (len_q[i]) check("t2_len", len_q[i], 3);

    // everyone requesting, one-byte messages, two rounds
    pulse_reset();
    clear_obs();
    for (int r = 0; r < NUM_REQ; r++) begin
      send_msg(r, 1, 1'b1);
      send_msg(r, 1, 1'b1);
    end
    drain(200);
    check("t3_order_len", order_q.size(), 2 * NUM_REQ);
    foreach (order_q[i]) check("t3_order", order_q[i], i % NUM_REQ);
    foreach (len_q[i]) check("t3_len", len_q[i], 1);

    // long stream without last: forced release every MAX_BURST bytes
    pulse_reset();
    clear_obs();
    send_msg(2, 40, 1'b0);
    drain(400);
    check("t4_releases", len_q.size(), 2);
    foreach (len_q[i]) check("t4_len", len_q[i], MAX_BURST);
    foreach (order_q[i]) check("t4_owner", order_q[i], 2);
    check("t4_tail_cnt", bus.burst_cnt, 8);
    check("t4_still_granted", bus.grant_valid, 1);
    check("t4_peak", max_cnt, MAX_BURST);

    // slow UART side, random gaps and lengths on every requester
    pulse_reset();
    clear_obs();
    gap_en = 1'b1;
    slow_ready = 1'b1;
    for (int m = 0; m < 3; m++) begin
      for (int r = 0; r < NUM_REQ; r++) send_msg(r, $urandom_range(1, 20), 1'b1);
    end
    drain(40000);

    // reset in the middle of a grant to requester 3
    pulse_reset();
    clear_obs();
    gap_en = 1'b0;
    slow_ready = 1'b0;
    send_msg(3, 10, 1'b1);
    n = 0;
    while (src_q[3].size() > 6 && n < 200) begin
      tick();
      n++;
    end
    check("t6_reach_byte5", src_q[3].size(), 6);
    pulse_reset();
    clear_obs();
    drain(200);
    check("t6_regrants", order_q.size(), 1);
    foreach (order_q[i]) check("t6_owner", order_q[i], 3);

    for (int r = 0; r < NUM_REQ; r++) check("sb_leftover", exp_q[r].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
